// File: rtl/buffer_ram_te_banked.sv
// Lane-masked ciphertext buffer RAM with a pipelined read port and a zero sweep.
// Define BUFFER_FWD_EN to forward same-edge writes (user and sweep) into reads.
module buffer_ram_te_banked #(
    parameter int DATA_SIZE    = 8,
    parameter int ELEMS        = 8,
    parameter int ADDR_BITS    = 7,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ADDR_BITS-1:0]          raddr,
    output logic [ELEMS*DATA_SIZE-1:0]    rdata,
    output logic                          rvalid,
    input  logic                          wren,
    input  logic [ADDR_BITS-1:0]          waddr,
    input  logic [ELEMS*DATA_SIZE-1:0]    wdata,
    input  logic [ELEMS-1:0]              wmask,
    input  logic                          clear_start,
    output logic                          clear_busy,
    output logic                          wr_drop
);

    localparam int W     = ELEMS * DATA_SIZE;
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_BITS-1:0]   clr_cnt;
    logic                   clr_we;
    logic                   usr_we;
    logic                   clr_go;
    logic                   drop_set;
    logic                   rd_ok;
    logic [W-1:0]           rd_word;
    logic [W-1:0]           mem [DEPTH];
    logic [W-1:0]           rd_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] rv_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The sweep leaves on its last address, so the counter never wraps inside it.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clear_start) state_nx = CLEAR;
            CLEAR:   if (clr_cnt == '1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = 1'b0;
        clr_we     = 1'b0;
        usr_we     = 1'b0;
        clr_go     = 1'b0;
        drop_set   = 1'b0;
        rd_ok      = 1'b0;
        unique case (1'b1)
            (state == CLEAR): begin
                clear_busy = 1'b1;
                clr_we     = 1'b1;
                drop_set   = wren && (|wmask);
            end
            default: begin
                usr_we = wren && (|wmask);
                clr_go = clear_start;
                rd_ok  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            if (clr_go) begin
                clr_cnt <= '0;
            end else if (clr_we) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (clr_go) begin
                wr_drop <= 1'b0;
            end else if (drop_set) begin
                wr_drop <= 1'b1;
            end
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (usr_we) begin
            for (int i = 0; i < ELEMS; i++) begin
                if (wmask[i]) begin
                    mem[waddr][DATA_SIZE*i +: DATA_SIZE] <=
                        wdata[DATA_SIZE*i +: DATA_SIZE];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[raddr];
`ifdef BUFFER_FWD_EN
        if (clr_we && (raddr == clr_cnt)) begin
            rd_word = '0;
        end else if (usr_we && (raddr == waddr)) begin
            for (int i = 0; i < ELEMS; i++) begin
                if (wmask[i]) begin
                    rd_word[DATA_SIZE*i +: DATA_SIZE] =
                        wdata[DATA_SIZE*i +: DATA_SIZE];
                end
            end
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_pipe[k] <= '0;
            end
            rv_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_word;
            rv_pipe[0] <= rd_ok;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
                rv_pipe[k] <= rv_pipe[k-1];
            end
        end
    end

    assign rdata  = rd_pipe[READ_LATENCY-1];
    assign rvalid = rv_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_buffer_ram_te_banked.sv
// Bench for buffer_ram_te_banked: directed table, hand sequences, random traffic
// against a lane-level memory model with a remaining-sweep-count state.
module tb_buffer_ram_te_banked;

    localparam int DW    = 8;
    localparam int E     = 8;
    localparam int AB    = 7;
    localparam int L     = 2;
    localparam int W     = DW * E;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AB-1:0] raddr;
    logic [W-1:0]  rdata;
    logic          rvalid;
    logic          wren;
    logic [AB-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [E-1:0]  wmask;
    logic          clear_start;
    logic          clear_busy;
    logic          wr_drop;

    buffer_ram_te_banked #(
        .DATA_SIZE(DW), .ELEMS(E), .ADDR_BITS(AB), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .rstn(rstn),
        .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .wren(wren), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           k;
        bit           v;
    } rd_t;

    typedef struct {
        int           kind;
        logic [AB-1:0] a;
        logic [W-1:0] d;
        logic [E-1:0] m;
        logic [W-1:0] exp;
    } vec_t;

    logic [W-1:0] mdl [DEPTH];
    bit           known [DEPTH];
    int           clr_left;
    int           clr_ptr;
    bit           drop;
    rd_t          q[$];
    int           n_vec;
    int           n_err;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        clr_left = 0;
        clr_ptr  = 0;
        drop     = 0;
        for (int a = 0; a < DEPTH; a++) known[a] = 0;
        q.delete();
        for (int k = 0; k < L - 1; k++) begin
            rd_t r;
            r.d = '0;
            r.k = 1;
            r.v = 0;
            q.push_back(r);
        end
    endtask

    task automatic step(input logic [AB-1:0] ra, input logic we,
                        input logic [AB-1:0] wa, input logic [W-1:0] wd,
                        input logic [E-1:0] wm, input logic cs);
        rd_t r;
        rd_t o;
        bit  idle;
        raddr       = ra;
        wren        = we;
        waddr       = wa;
        wdata       = wd;
        wmask       = wm;
        clear_start = cs;
        @(posedge clk);
        idle = (clr_left == 0);
        r.d  = mdl[ra];
        r.k  = known[ra];
        r.v  = idle;
        if (idle) begin
            if (we && wm != 0) begin
                for (int i = 0; i < E; i++)
                    if (wm[i]) mdl[wa][DW*i +: DW] = wd[DW*i +: DW];
                if (wm == '1) known[wa] = 1;
`ifdef BUFFER_FWD_EN
                if (wa == ra) begin
                    r.d = mdl[wa];
                    r.k = known[wa];
                end
`endif
            end
            if (cs) begin
                clr_left = DEPTH;
                clr_ptr  = 0;
                drop     = 0;
            end
        end else begin
            if (we && wm != 0) drop = 1;
`ifdef BUFFER_FWD_EN
            if (int'(ra) == clr_ptr) begin
                r.d = '0;
                r.k = 1;
            end
`endif
            mdl[clr_ptr]   = '0;
            known[clr_ptr] = 1;
            clr_ptr++;
            clr_left--;
        end
        q.push_back(r);
        #1;
        if (q.size() >= L) begin
            o = q.pop_front();
            chk("rvalid", W'(rvalid), W'(o.v));
            if (o.k) chk("rdata", rdata, o.d);
        end
        chk("clear_busy", W'(clear_busy), W'(clr_left != 0));
        chk("wr_drop", W'(wr_drop), W'(drop));
    endtask

    task automatic idle_step();
        step('0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [7];
        int   cnt;
        logic [W-1:0] first_d;
        logic [W-1:0] fwd_exp;

        tbl[0] = '{0, 7'd5, 64'h0807060504030201, 8'hFF, 64'h0};
        tbl[1] = '{2, 7'd0, 64'h0, 8'h00, 64'h0};
        tbl[2] = '{1, 7'd5, 64'h0, 8'h00, 64'h0807060504030201};
        tbl[3] = '{0, 7'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0};
        tbl[4] = '{1, 7'd5, 64'h0, 8'h00, 64'h08070605AAAAAAAA};
        tbl[5] = '{0, 7'd9, 64'h1111111111111111, 8'hFF, 64'h0};
        tbl[6] = '{1, 7'd9, 64'h0, 8'h00, 64'h1111111111111111};

        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        raddr = '0; wren = 1'b0; waddr = '0; wdata = '0;
        wmask = '0; clear_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, '0);
        chk("rst_rvalid", W'(rvalid), '0);
        chk("rst_busy", W'(clear_busy), '0);
        chk("rst_drop", W'(wr_drop), '0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            unique case (tbl[i].kind)
                0: step('0, 1'b1, tbl[i].a, tbl[i].d, tbl[i].m, 1'b0);
                1: begin
                    step(tbl[i].a, 1'b0, '0, '0, '0, 1'b0);
                    for (int k = 0; k < L - 1; k++) idle_step();
                    chk("tbl_read", rdata, tbl[i].exp);
                    chk("tbl_rvalid", W'(rvalid), W'(1'b1));
                end
                default: step('0, 1'b1, tbl[i].a, tbl[i].d, tbl[i].m, 1'b0);
            endcase
        end

`ifdef BUFFER_FWD_EN
        fwd_exp = 64'h2222222222222222;
`else
        fwd_exp = 64'h1111111111111111;
`endif
        first_d = 64'h2222222222222222;
        for (int j = 0; j <= L; j++) begin
            if (j == 0) step(7'd9, 1'b1, 7'd9, first_d, 8'hFF, 1'b0);
            else if (j == 1) step(7'd9, 1'b0, '0, '0, '0, 1'b0);
            else idle_step();
            if (j == L - 1) chk("same_edge", rdata, fwd_exp);
            if (j == L) chk("next_edge", rdata, 64'h2222222222222222);
        end

        for (int n = 0; n < 400; n++) begin
            step(AB'($urandom), 1'($urandom), AB'($urandom),
                 {$urandom, $urandom}, E'($urandom),
                 ($urandom_range(0, 99) == 0));
        end
        cnt = 0;
        while (clear_busy && cnt < 2 * DEPTH) begin
            idle_step();
            cnt++;
        end

        for (int a = 0; a < DEPTH; a++)
            step(AB'($urandom), 1'b1, AB'(a), {$urandom, $urandom} | 64'h1,
                 8'hFF, 1'b0);

        step(AB'($urandom), 1'b0, '0, '0, '0, 1'b1);
        cnt = 0;
        while (clear_busy && cnt < DEPTH + 10) begin
            step(AB'($urandom), (cnt == 20), 7'd3, 64'h5555555555555555,
                 8'hFF, (cnt == 50));
            cnt++;
        end
        chk("busy_len", W'(cnt), W'(DEPTH));
        chk("drop_sticky", W'(wr_drop), W'(1'b1));
        for (int a = 0; a < DEPTH; a++)
            step(AB'(a), 1'b0, '0, '0, '0, 1'b0);
        step(7'd3, 1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < L - 1; k++) idle_step();
        chk("addr3_zero", rdata, '0);
        step('0, 1'b0, '0, '0, '0, 1'b1);
        chk("drop_clr", W'(wr_drop), '0);
        cnt = 0;
        while (clear_busy && cnt < DEPTH + 10) begin
            idle_step();
            cnt++;
        end

        step('0, 1'b0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 100; k++) step(7'd5, 1'b0, '0, '0, '0, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_busy", W'(clear_busy), '0);
        chk("arst_rdata", rdata, '0);
        chk("arst_rvalid", W'(rvalid), '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        step('0, 1'b0, '0, '0, '0, 1'b1);
        cnt = 0;
        while (clear_busy && cnt < DEPTH + 10) begin
            idle_step();
            cnt++;
        end
        chk("busy_len2", W'(cnt), W'(DEPTH));
        for (int a = 0; a < DEPTH; a++)
            step(AB'(a), 1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < L; k++) idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/buffer_ram_te_banked.md
Name: buffer_ram_te_banked

Overview:
- E-lane ciphertext buffer RAM that sits directly upstream/downstream of the automorphism control.
- Serves one full-width read per cycle (raddr in, rdata after fixed latency) and one lane-masked write per cycle (permuted data written back).
- Adds a hardware clear sweep so the buffer can be zeroed between transforms without host traffic.

Parameters:
- DATA_SIZE, FSIZE, width of one coefficient lane.
- ELEMS, E, lanes per word.
- ADDR_BITS, logN-logE, word address width; depth = 2^ADDR_BITS.
- READ_LATENCY, BUFFER_READ_LATENCY, cycles from raddr sample to rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- raddr  in  ADDR_BITS  read address, sampled every cycle (no read enable)
- rdata  out  ELEMS*DATA_SIZE  read data, lane i at bits [DATA_SIZE*i +: DATA_SIZE]
- rvalid  out  1  high when rdata corresponds to a read issued while not clearing
- wren  in  1  write request
- waddr  in  ADDR_BITS  write address
- wdata  in  ELEMS*DATA_SIZE  write data
- wmask  in  ELEMS  per-lane write enable; lane i written only if wmask[i]=1
- clear_start  in  1  one-cycle pulse, starts zero sweep
- clear_busy  out  1  sweep in progress
- wr_drop  out  1  sticky: an external write was discarded during a sweep; cleared by the next clear_start or reset

Behaviour:
- Storage: 2^ADDR_BITS x ELEMS*DATA_SIZE array. The array is not reset; all pipeline/control registers reset asynchronously.
- Reset values: rdata=0, rvalid=0, clear_busy=0, wr_drop=0, state=IDLE, clear counter=0.
- Read pipeline:
  - raddr is captured at edge T; rdata/rvalid are valid after edge T+READ_LATENCY-1 (READ_LATENCY=1 means registered output the cycle after raddr is presented).
  - Throughput is one read per cycle.
  - rvalid for a read is 1 iff state was IDLE when raddr was captured.
- Write:
  - The write commits at the edge where wren=1 is sampled, to lanes with wmask[i]=1 only.
  - wren=1 with wmask=0 has no effect on the array and is not a drop.
- Same-edge read/write to the same address: see BUFFER_FWD_EN.
- State machine IDLE/CLEAR:
  - IDLE, clear_start=1: go to CLEAR; counter=0; wr_drop cleared; clear_busy=1 from the next cycle.
  - CLEAR, each cycle: write all-zero word (all lanes) to address=counter, then counter+1.
  - CLEAR with counter = 2^ADDR_BITS-1: final write, return to IDLE; clear_busy=0 the following cycle.
  - A sweep takes exactly 2^ADDR_BITS cycles.
  - clear_start while in CLEAR is ignored; the counter is not restarted.
  - wren=1 with nonzero wmask in CLEAR: write discarded, wr_drop set; it stays 1 until cleared.
  - clear_start and wren in the same IDLE cycle: the write commits first, then the sweep starts; the sweep later zeros that address.
- Reset mid-sweep: state=IDLE immediately; array contents are partially cleared and undefined to the bench.
- Counter width is ADDR_BITS; it never wraps inside a sweep because the FSM leaves at the last address.

Optional Feature:
- BUFFER_FWD_EN defined:
  - A read captured at the same edge a write commits to the same address returns the merged word: new data in masked lanes, old data elsewhere.
  - Sweep writes are forwarded too; those reads still have rvalid=0.
- BUFFER_FWD_EN undefined:
  - The same-edge read returns the pre-write word.
  - The new data is visible to reads captured one edge later.

Test Plan:
- Write addr 5 = lanes {1..8}, wmask=0xFF; read addr 5 two cycles later -> rdata lanes {1..8} exactly READ_LATENCY cycles after raddr, rvalid=1.
- Preload addr 5 = {1..8}; write addr 5 = all 0xAA, wmask=0x0F -> read returns lanes0-3=0xAA, lanes4-7={5,6,7,8}.
- Preload addr 9 = all 0x11; same-cycle write of all 0x22 and read of addr 9 -> 0x22 lanes with BUFFER_FWD_EN, 0x11 lanes without; next-cycle read returns 0x22 in both builds.
- Fill all addresses nonzero; pulse clear_start -> clear_busy high exactly 2^ADDR_BITS cycles; then every address reads 0; second clear_start mid-sweep does not lengthen busy.
- During a sweep, wren=1 to addr 3, wmask=0xFF -> wr_drop=1 and stays 1; addr 3 reads 0 after the sweep; next clear_start clears wr_drop.
- Deassert rstn at sweep address 100 -> clear_busy=0, rdata=0, rvalid=0 asynchronously; after release the block accepts a new clear_start.
